// File: rtl/io_ctrl_pkg.sv
// Shared types and constants for the CPU port-I/O bus controller.
// Optional timeout logic in io_bus_ctrl is enabled by defining IOCTRL_TIMEOUT_EN.
package io_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int ERR_DROP = 0;
  localparam int ERR_TMO  = 1;

  localparam logic [15:0] TMO_RDATA = 16'hFFFF;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_entry_t;

  // Sticky error update: a new error in the same cycle as a clear survives.
  function automatic logic [1:0] err_update(input logic [1:0] cur,
                                            input logic [1:0] set,
                                            input logic       clr);
    logic [1:0] kept;
    kept = clr ? 2'b00 : cur;
    return kept | set;
  endfunction

endpackage

// File: rtl/io_wr_fifo.sv
// Posted-write FIFO (DEPTH x {addr,data}); pointers carry one extra wrap bit
// so full/empty come from comparing the top bit.
module io_wr_fifo
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_INC  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wr_entry_t   mem_r [DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign full      = ((wr_ptr_r ^ rd_ptr_r) == PTR_WRAP);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; a push into a full FIFO is ignored even if a pop happens the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_INC;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/io_bus_ctrl.sv
// CPU port-I/O sequencer: posted writes via io_wr_fifo, reads ordered behind them,
// one bus transaction at a time. Define IOCTRL_TIMEOUT_EN to abort stalled transfers.
module io_bus_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [15:0] cpu_in,
  output logic        rd_done,
  output logic        cpu_busy,
  output logic        per_valid,
  output logic        per_we,
  output logic [15:0] per_addr,
  output logic [15:0] per_wdata,
  input  logic        per_ready,
  input  logic [15:0] per_rdata,
  output logic [1:0]  err,
  input  logic        err_clr
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("io_bus_ctrl: DEPTH or TIMEOUT out of range");
  end

  state_e      state_r;
  logic        per_valid_r;
  logic        per_we_r;
  logic [15:0] per_addr_r;
  logic [15:0] per_wdata_r;
  logic [15:0] cpu_in_r;
  logic        rd_done_r;
  logic        rd_pending_r;
  logic [15:0] rd_addr_r;
  logic [1:0]  err_r;

  wr_entry_t   head_s;
  wr_entry_t   push_entry_s;
  logic        full_s;
  logic        empty_s;
  logic        push_s;
  logic        pop_s;
  logic        rd_accept_s;
  logic        tmo_s;
  logic        xfer_end_s;
  logic [1:0]  err_set_s;

  assign push_entry_s = '{addr: cpu_addr, data: cpu_data};

  io_wr_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .din   (push_entry_s),
    .pop   (pop_s),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

`ifdef IOCTRL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt_r;

  // Wait-cycle counter, restarted whenever the FSM passes through IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt_r <= 16'h0000;
    end else if (state_r == ST_IDLE || per_ready) begin
      tmo_cnt_r <= 16'h0000;
    end else begin
      tmo_cnt_r <= tmo_cnt_r + 16'h0001;
    end
  end

  assign tmo_s = (state_r != ST_IDLE) & ~per_ready & (tmo_cnt_r == TMO_LAST);
`else
  assign tmo_s = 1'b0;
`endif

  // Request acceptance, transfer completion and error sources.
  always_comb begin
    push_s      = cpu_wr & ~full_s;
    rd_accept_s = cpu_rd & ~rd_pending_r;
    xfer_end_s  = per_ready | tmo_s;
    err_set_s   = 2'b00;
    err_set_s[ERR_DROP] = (cpu_wr & full_s) | (cpu_rd & rd_pending_r);
    err_set_s[ERR_TMO]  = tmo_s;
    if (state_r == ST_WRITE) begin
      pop_s = xfer_end_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  assign cpu_busy = full_s | rd_pending_r | (state_r == ST_READ);

  // Main FSM; IDLE also looks at this cycle's strobes so a request reaches the bus one cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      per_valid_r  <= 1'b0;
      per_we_r     <= 1'b0;
      per_addr_r   <= 16'h0000;
      per_wdata_r  <= 16'h0000;
      cpu_in_r     <= 16'h0000;
      rd_done_r    <= 1'b0;
      rd_pending_r <= 1'b0;
      rd_addr_r    <= 16'h0000;
      err_r        <= 2'b00;
    end else begin
      rd_done_r <= 1'b0;
      err_r     <= err_update(err_r, err_set_s, err_clr);
      if (rd_accept_s) begin
        rd_pending_r <= 1'b1;
        rd_addr_r    <= cpu_addr;
      end
      case (state_r)
        ST_IDLE: begin
          if (!empty_s) begin
            state_r     <= ST_WRITE;
            per_valid_r <= 1'b1;
            per_we_r    <= 1'b1;
            per_addr_r  <= head_s.addr;
            per_wdata_r <= head_s.data;
          end else if (push_s) begin
            state_r     <= ST_WRITE;
            per_valid_r <= 1'b1;
            per_we_r    <= 1'b1;
            per_addr_r  <= cpu_addr;
            per_wdata_r <= cpu_data;
          end else if (rd_pending_r) begin
            state_r     <= ST_READ;
            per_valid_r <= 1'b1;
            per_we_r    <= 1'b0;
            per_addr_r  <= rd_addr_r;
          end else if (rd_accept_s) begin
            state_r     <= ST_READ;
            per_valid_r <= 1'b1;
            per_we_r    <= 1'b0;
            per_addr_r  <= cpu_addr;
          end
        end
        ST_WRITE: begin
          if (xfer_end_s) begin
            state_r     <= ST_IDLE;
            per_valid_r <= 1'b0;
            per_we_r    <= 1'b0;
          end
        end
        ST_READ: begin
          if (xfer_end_s) begin
            state_r      <= ST_IDLE;
            per_valid_r  <= 1'b0;
            cpu_in_r     <= per_ready ? per_rdata : TMO_RDATA;
            rd_done_r    <= 1'b1;
            rd_pending_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          per_valid_r <= 1'b0;
          per_we_r    <= 1'b0;
        end
      endcase
    end
  end

  assign per_valid = per_valid_r;
  assign per_we    = per_we_r;
  assign per_addr  = per_addr_r;
  assign per_wdata = per_wdata_r;
  assign cpu_in    = cpu_in_r;
  assign rd_done   = rd_done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Scoreboard bench for io_bus_ctrl: stimulus queues expected bus transfers and
// read results; a negedge monitor pops and compares them.
module tb_io_bus_ctrl;

`ifdef IOCTRL_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = 16'h0000;
  logic [15:0] cpu_data = 16'h0000;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [15:0] cpu_in;
  logic        rd_done;
  logic        cpu_busy;
  logic        per_valid;
  logic        per_we;
  logic [15:0] per_addr;
  logic [15:0] per_wdata;
  logic        per_ready = 1'b0;
  logic [15:0] per_rdata = 16'h0000;
  logic [1:0]  err;
  logic        err_clr = 1'b0;

  io_bus_ctrl #(.DEPTH(4), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_in(cpu_in), .rd_done(rd_done),
    .cpu_busy(cpu_busy), .per_valid(per_valid), .per_we(per_we),
    .per_addr(per_addr), .per_wdata(per_wdata), .per_ready(per_ready),
    .per_rdata(per_rdata), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [15:0] rd_q[$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted bus transfer and every rd_done must match the queue head.
  always @(negedge clk) begin
    if (reset) begin
      if (per_valid && per_ready) begin
        if (bus_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_xfer: got we=%b addr=%h, expected no transfer", per_we, per_addr);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_we", {31'h0, per_we}, {31'h0, b.we});
          chk("bus_addr", {16'h0, per_addr}, {16'h0, b.addr});
          if (b.we) chk("bus_wdata", {16'h0, per_wdata}, {16'h0, b.data});
        end
      end
      if (rd_done) begin
        if (rd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rd_done: got cpu_in=%h, expected no completion", cpu_in);
        end else begin
          logic [15:0] r;
          r = rd_q.pop_front();
          chk("cpu_in", {16'h0, cpu_in}, {16'h0, r});
        end
      end
    end
  end

  task automatic wr_pulse(input logic [15:0] a, input logic [15:0] d, input bit exp_bus);
    cpu_addr = a;
    cpu_data = d;
    cpu_wr   = 1'b1;
    if (exp_bus) bus_q.push_back('{1'b1, a, d});
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic rd_pulse(input logic [15:0] a, input bit exp_bus, input bit exp_done,
                          input logic [15:0] rexp);
    cpu_addr = a;
    cpu_rd   = 1'b1;
    if (exp_bus) bus_q.push_back('{1'b0, a, 16'h0000});
    if (exp_done) rd_q.push_back(rexp);
    tick();
    cpu_rd = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && (bus_q.size() != 0 || rd_q.size() != 0); i++) tick();
    chk(name, bus_q.size() + rd_q.size(), 32'd0);
    tick();
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", {30'h0, err}, 32'd0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) tick();
    chk("rst_per_valid", {31'h0, per_valid}, 32'd0);
    chk("rst_per_we", {31'h0, per_we}, 32'd0);
    chk("rst_per_addr", {16'h0, per_addr}, 32'd0);
    chk("rst_per_wdata", {16'h0, per_wdata}, 32'd0);
    chk("rst_cpu_in", {16'h0, cpu_in}, 32'd0);
    chk("rst_rd_done", {31'h0, rd_done}, 32'd0);
    chk("rst_cpu_busy", {31'h0, cpu_busy}, 32'd0);
    chk("rst_err", {30'h0, err}, 32'd0);
    reset = 1'b1;
    tick();

    // Single write, ready tied high: one valid cycle right after the strobe
    per_ready = 1'b1;
    wr_pulse(16'h0001, 16'h00AA, 1'b1);
    chk("w1_valid", {31'h0, per_valid}, 32'd1);
    chk("w1_we", {31'h0, per_we}, 32'd1);
    chk("w1_addr", {16'h0, per_addr}, 32'h0001);
    chk("w1_data", {16'h0, per_wdata}, 32'h00AA);
    tick();
    chk("w1_valid_drop", {31'h0, per_valid}, 32'd0);
    chk("w1_busy", {31'h0, cpu_busy}, 32'd0);
    drain("w1_drain");

    // Fill the FIFO while stalled, overflow drops, then release in order
    per_ready = 1'b0;
    wr_pulse(16'h0101, 16'h1111, 1'b1);
    wr_pulse(16'h0102, 16'h2222, 1'b1);
    wr_pulse(16'h0103, 16'h3333, 1'b1);
    chk("fill3_busy", {31'h0, cpu_busy}, 32'd0);
    wr_pulse(16'h0104, 16'h4444, 1'b1);
    chk("full_busy", {31'h0, cpu_busy}, 32'd1);
    chk("stall_addr", {16'h0, per_addr}, 32'h0101);
    wr_pulse(16'h0105, 16'h5555, 1'b0);
    chk("overflow_err", {30'h0, err}, 32'd1);
    per_ready = 1'b1;
    drain("fill_drain");
    clear_err();

    // Two writes then a read: read is ordered behind both
    per_rdata = 16'h1234;
    wr_pulse(16'h0201, 16'hAAAA, 1'b1);
    wr_pulse(16'h0202, 16'hBBBB, 1'b1);
    rd_pulse(16'h0010, 1'b1, 1'b1, 16'h1234);
    drain("wwr_drain");
    chk("wwr_cpu_in", {16'h0, cpu_in}, 32'h1234);

    // Read latency from IDLE with an empty FIFO
    per_rdata = 16'hBEEF;
    rd_pulse(16'h0020, 1'b1, 1'b1, 16'hBEEF);
    chk("rd_lat_valid", {31'h0, per_valid}, 32'd1);
    chk("rd_lat_we", {31'h0, per_we}, 32'd0);
    chk("rd_lat_addr", {16'h0, per_addr}, 32'h0020);
    tick();
    chk("rd_lat_done", {31'h0, rd_done}, 32'd1);
    chk("rd_lat_cpu_in", {16'h0, cpu_in}, 32'hBEEF);
    drain("rd_lat_drain");

    // Simultaneous write+read, then a second read while one is pending
    per_ready = 1'b0;
    per_rdata = 16'h0A0B;
    cpu_addr = 16'h0030;
    cpu_data = 16'h5555;
    cpu_wr = 1'b1;
    cpu_rd = 1'b1;
    bus_q.push_back('{1'b1, 16'h0030, 16'h5555});
    bus_q.push_back('{1'b0, 16'h0030, 16'h0000});
    rd_q.push_back(16'h0A0B);
    tick();
    cpu_wr = 1'b0;
    cpu_rd = 1'b0;
    rd_pulse(16'h0040, 1'b0, 1'b0, 16'h0000);
    chk("rd_drop_err", {30'h0, err}, 32'd1);
    chk("rd_pend_busy", {31'h0, cpu_busy}, 32'd1);
    per_ready = 1'b1;
    drain("wr_rd_drain");
    chk("err_sticky", {30'h0, err}, 32'd1);
    clear_err();

`ifdef IOCTRL_TIMEOUT_EN
    // Stalled read aborts after TIMEOUT wait cycles
    per_ready = 1'b0;
    rd_pulse(16'h0050, 1'b0, 1'b1, 16'hFFFF);
    n = 0;
    for (int i = 0; i < 40 && per_valid; i++) begin
      n++;
      tick();
    end
    chk("tmo_wait_cycles", n, 32'd8);
    chk("tmo_rd_done", {31'h0, rd_done}, 32'd1);
    chk("tmo_cpu_in", {16'h0, cpu_in}, 32'hFFFF);
    chk("tmo_err", {30'h0, err}, 32'd2);
    drain("tmo_drain");
    clear_err();
`endif

    // Reset in the middle of a stalled write with 3 queued and a read pending
    per_ready = 1'b0;
    wr_pulse(16'h0301, 16'h0C01, 1'b0);
    wr_pulse(16'h0302, 16'h0C02, 1'b0);
    wr_pulse(16'h0303, 16'h0C03, 1'b0);
    rd_pulse(16'h0310, 1'b0, 1'b0, 16'h0000);
    cpu_rd = 1'b1;
    err_clr = 1'b1;
    tick();
    cpu_rd = 1'b0;
    err_clr = 1'b0;
    chk("err_set_wins", {30'h0, err}, 32'd1);
    chk("pre_rst_valid", {31'h0, per_valid}, 32'd1);
    chk("pre_rst_addr", {16'h0, per_addr}, 32'h0301);
    reset = 1'b0;
    tick();
    chk("midrst_valid", {31'h0, per_valid}, 32'd0);
    chk("midrst_cpu_in", {16'h0, cpu_in}, 32'd0);
    chk("midrst_err", {30'h0, err}, 32'd0);
    chk("midrst_busy", {31'h0, cpu_busy}, 32'd0);
    bus_q.delete();
    rd_q.delete();
    reset = 1'b1;
    per_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (per_valid || rd_done) n++;
      tick();
    end
    chk("post_rst_idle", n, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
